serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial adder for WIDTH-bit operands. It uses one full-adder cell plus a carry flip-flop, consuming one bit pair per clock, LSB first. The block sits one stage above the single-bit full adder: it accepts a parallel operand pair with a valid/ready handshake and sequences it through the cell. It returns a parallel sum and carry-out with a valid/ready handshake.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair a/b/cin present
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A, sampled only on acceptance
b  input  WIDTH  operand B, sampled only on acceptance
cin  input  1  carry-in, sampled only on acceptance
out_valid  output  1  sum/cout valid (high only in DONE)
out_ready  input  1  consumer takes the result
sum  output  WIDTH  registered sum
cout  output  1  registered final carry
busy  output  1  high in RUN

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset, asserted at any time including mid-operation:
  - state goes to IDLE immediately.
  - Operand shift registers, sum register, carry register and bit counter all clear to 0.
  - Outputs: out_valid=0, sum=0, cout=0, busy=0, in_ready=1.
  - No partial result survives reset.
- State machine, states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On an edge with in_valid=1:
    - Load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0.
    - Go to RUN.
  - RUN: in_ready=0, busy=1. Every edge:
    - (s,c) = full_add(a_sh[0], b_sh[0], carry).
    - sum_sh <= {s, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1 with zero fill; carry<=c; cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1, go to DONE.
  - DONE: out_valid=1; sum=sum_sh; cout=carry. sum, cout and out_valid hold stable until an edge with out_ready=1, then go to IDLE.
- Latency and throughput:
  - out_valid rises after exactly WIDTH rising edges following the accepting edge.
  - Minimum op-to-op spacing is WIDTH+2 cycles (one DONE cycle, one IDLE cycle).
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). Counter width is $clog2(WIDTH); the counter does not wrap past WIDTH-1.
- Boundary conditions:
  - in_valid outside IDLE is ignored, with no queueing.
  - out_ready outside DONE is ignored.
  - Changes on a/b/cin after acceptance have no effect.
  - in_valid held high continuously starts a new operation on every IDLE edge.
  - out_valid and in_ready are never high together.
- sum and cout are driven from registers, with no combinational path from inputs to outputs. in_ready, out_valid and busy decode state only.

Decomposition:
- Shared package serial_adder_pkg:
  - State encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Default WIDTH constant.
- Sub-module fa_cell (ports a, b, ci, s, co): purely combinational dataflow full adder, s=a^b^ci, co=ab|aci|bci. It is instantiated once in serial_adder; no other arithmetic is inline.

Test Plan:
1. Reset: rst asserted between edges.
   - Required: outputs reach reset values without waiting for clk (out_valid=0, sum=0x00, cout=0, busy=0, in_ready=1).
   - Required: after release with in_valid=0 for 5 cycles, nothing changes.
2. Basic add with latency check: WIDTH=8, a=0x5A, b=0x33, cin=0.
   - Required: busy high for 8 cycles.
   - Required: out_valid rises exactly 8 edges after acceptance, with sum=0x8D, cout=0.
3. Carry ripple: a=0xFF, b=0x01, cin=0 gives sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 gives sum=0xFF, cout=1.
4. Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
   - Required: out_valid, sum and cout stay stable; in_ready=0; new operands are not accepted.
   - Required: out_ready=1 for one edge returns the block to IDLE; the next edge accepts the pending operands.
5. Reset mid-RUN: a=0xAA, b=0x55; assert rst after 3 RUN edges.
   - Required: immediate IDLE with outputs at reset values.
   - Required: a following op a=0x01, b=0x01, cin=0 gives sum=0x02, cout=0, with no leftover carry.
6. Operand isolation: change a/b/cin every cycle during RUN after accepting a=0x10, b=0x20, cin=1.
   - Required: sum=0x31, cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// Single-bit combinational full adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first,
// with valid/ready handshakes on the parallel operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)        state_nx = RUN;
      RUN:     if (cnt == CNT_LAST) state_nx = DONE;
      DONE:    if (out_ready)       state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at sum_sh[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
          end
        end
        RUN: begin
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= fa_co;
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign sum       = sum_sh;
  assign cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized ops
// compared against plain integer addition.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int unsigned r;
    r = int'(x) + int'(y) + int'(c);
    return (W+1)'(r % (1 << (W + 1)));
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_sum"},       32'(sum),       32'd0);
    check({tag, "_cout"},      32'(cout),      32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  // Called at a negedge; presents operands, returns at the negedge after acceptance.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("start_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = c;
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
  endtask

  // Waits (bounded) for DONE, optionally scrambling inputs during RUN, then checks result and latency.
  task automatic wait_done(input logic [W:0] exp, input bit scramble);
    int n;
    int busyc;
    n = 0;
    busyc = 0;
    while (!out_valid && n < 20) begin
      if (busy) busyc++;
      check("run_in_ready", 32'(in_ready), 32'd0);
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        in_valid = 1'($urandom);
        out_ready = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("latency", 32'(n), 32'(W));
    check("busy_cycles", 32'(busyc), 32'(W));
    check("done_out_valid", 32'(out_valid), 32'd1);
    check("done_in_ready", 32'(in_ready), 32'd0);
    check("sum", 32'(sum), 32'(exp[W-1:0]));
    check("cout", 32'(cout), 32'(exp[W]));
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   e1;

    // Reset asserted between clock edges must act without a clock.
    #12;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_reset_outputs("rst_idle");
    end

    // Basic add and latency.
    start_op(8'h5A, 8'h33, 1'b0);
    wait_done(9'h08D, 1'b0);
    release_result();

    // Carry ripple.
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(9'h100, 1'b0);
    release_result();
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done(9'h1FF, 1'b0);
    release_result();

    // Backpressure with pending operands.
    start_op(8'h12, 8'h34, 1'b1);
    wait_done(9'h047, 1'b0);
    in_valid = 1'b1;
    a = 8'hC0;
    b = 8'h50;
    cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h47);
      check("bp_cout", 32'(cout), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_pending_accepted", 32'(busy), 32'd1);
    wait_done(ref_add(8'hC0, 8'h50, 1'b1), 1'b0);
    release_result();

    // Reset in the middle of RUN.
    start_op(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_run");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid_after");
    start_op(8'h01, 8'h01, 1'b0);
    wait_done(9'h002, 1'b0);
    release_result();

    // Operand isolation: inputs wiggle throughout RUN.
    start_op(8'h10, 8'h20, 1'b1);
    wait_done(9'h031, 1'b1);
    release_result();

    // Randomized ops with random result backpressure.
    for (int t = 0; t < 40; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if (t == 0) begin ra = '1; rb = '1; rc = 1'b1; end
      if (t == 1) begin ra = '0; rb = '0; rc = 1'b0; end
      e1 = ref_add(ra, rb, rc);
      start_op(ra, rb, rc);
      wait_done(e1, (t % 2) == 1);
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
        @(negedge clk);
        check("rnd_hold_sum", 32'(sum), 32'(e1[W-1:0]));
        check("rnd_hold_cout", 32'(cout), 32'(e1[W]));
        check("rnd_hold_valid", 32'(out_valid), 32'd1);
      end
      release_result();
    end

    // Continuous in_valid: back-to-back ops at minimum spacing.
    in_valid = 1'b1;
    a = 8'h7F;
    b = 8'h01;
    cin = 1'b0;
    @(negedge clk);
    check("b2b_first_busy", 32'(busy), 32'd1);
    wait_done(9'h080, 1'b0);
    in_valid = 1'b1;
    a = 8'h80;
    b = 8'h80;
    cin = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_second_busy", 32'(busy), 32'd1);
    wait_done(9'h101, 1'b0);
    release_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
